// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller: fetch/decode/execute/memory/writeback sequencing,
// instruction register, datapath control generation and a ready-wait watchdog.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_rdata,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic [31:0] ir_q,
  output logic [1:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        instret,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [31:0]       ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;
  logic              timeout_hit;
  logic [6:0]        op_q, op_n;

  logic              imem_req_q, imem_req_d;
  logic              alu_src_a_q, alu_src_a_d;
  logic              alu_src_b_q, alu_src_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              dmem_re_q, dmem_re_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_we_q, rf_we_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic              pc_we_q, pc_we_d;
  logic              pc_sel_q, pc_sel_d;
  logic              instret_q, instret_d;

  logic              exec_branch;
  logic              store_done;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                                                     is_legal = 1'b0;
    endcase
  endfunction

  assign op_q        = ir_q[6:0];
  assign op_n        = ir_d[6:0];
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= LIMIT);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = '0;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = instr_rdata;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        if (is_legal(op_q)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_IMM, OP_JAL, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:             state_d = S_MEM;
          OP_BRANCH:                     state_d = S_FETCH;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with that state.
  always_comb begin
    imem_req_d  = 1'b0;
    alu_src_a_d = 1'b0;
    alu_src_b_d = 1'b0;
    alu_op_d    = 2'b00;
    dmem_re_d   = 1'b0;
    dmem_we_d   = 1'b0;
    rf_we_d     = 1'b0;
    wb_sel_d    = 2'b00;
    pc_we_d     = 1'b0;
    pc_sel_d    = 1'b0;
    instret_d   = 1'b0;
    case (state_d)
      S_FETCH: imem_req_d = 1'b1;
      S_EXEC: begin
        case (op_n)
          OP_R:   alu_op_d = 2'b01;
          OP_IMM: begin
            alu_src_b_d = 1'b1;
            alu_op_d    = 2'b10;
          end
          OP_LOAD, OP_STORE, OP_JALR: alu_src_b_d = 1'b1;
          OP_BRANCH: alu_op_d = 2'b11;
          OP_JAL: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_src_b_d = 1'b1;
        dmem_re_d   = (op_n == OP_LOAD);
        dmem_we_d   = (op_n == OP_STORE);
      end
      S_WB: begin
        rf_we_d   = 1'b1;
        pc_we_d   = 1'b1;
        instret_d = 1'b1;
        case (op_n)
          OP_LOAD: wb_sel_d = 2'b01;
          OP_JAL, OP_JALR: begin
            wb_sel_d    = 2'b10;
            pc_sel_d    = 1'b1;
            alu_src_a_d = (op_n == OP_JAL);
            alu_src_b_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      cnt_q       <= '0;
      trap_q      <= 1'b0;
      cause_q     <= 2'b00;
      imem_req_q  <= 1'b0;
      alu_src_a_q <= 1'b0;
      alu_src_b_q <= 1'b0;
      alu_op_q    <= 2'b00;
      dmem_re_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      wb_sel_q    <= 2'b00;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      instret_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      trap_q      <= trap_d;
      cause_q     <= cause_d;
      imem_req_q  <= imem_req_d;
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
      alu_op_q    <= alu_op_d;
      dmem_re_q   <= dmem_re_d;
      dmem_we_q   <= dmem_we_d;
      rf_we_q     <= rf_we_d;
      wb_sel_q    <= wb_sel_d;
      pc_we_q     <= pc_we_d;
      pc_sel_q    <= pc_sel_d;
      instret_q   <= instret_d;
    end
  end

  // Branch resolution and store completion depend on same-cycle inputs, so they bypass the registers.
  assign exec_branch = (state_q == S_EXEC) && (op_q == OP_BRANCH);
  assign store_done  = (state_q == S_MEM) && (op_q == OP_STORE) && dmem_ready;

  always_comb begin
    imm_sel = 2'b00;
    if (state_q != S_IDLE && state_q != S_TRAP) begin
      case (op_q)
        OP_STORE:  imm_sel = 2'b01;
        OP_BRANCH: imm_sel = 2'b10;
        OP_JAL:    imm_sel = 2'b11;
        default:   imm_sel = 2'b00;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign alu_src_a  = alu_src_a_q | (exec_branch & br_taken);
  assign alu_src_b  = alu_src_b_q | (exec_branch & br_taken);
  assign alu_op     = alu_op_q;
  assign dmem_re    = dmem_re_q;
  assign dmem_we    = dmem_we_q;
  assign rf_we      = rf_we_q;
  assign wb_sel     = wb_sel_q;
  assign pc_we      = pc_we_q | exec_branch | store_done;
  assign pc_sel     = pc_sel_q | (exec_branch & br_taken);
  assign instret    = instret_q | exec_branch | store_done;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by cycle
// and checks the full control vector against hand-derived values.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_rdata;
  logic        imem_ready;
  logic        dmem_ready;
  logic        br_taken;
  logic        imem_req;
  logic [31:0] ir_q;
  logic [1:0]  imm_sel;
  logic        alu_src_a;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        dmem_re;
  logic        dmem_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic        pc_sel;
  logic        instret;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;

  int compared = 0;
  int mismatched = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h00012183;
  localparam logic [31:0] I_SW   = 32'h00112223;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_BAD  = 32'h00000000;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_rdata(instr_rdata), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req), .ir_q(ir_q),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .instret(instret), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {state_o, imem_req, imm_sel, alu_src_a, alu_src_b, alu_op, dmem_re, dmem_we,
                rf_we, wb_sel, pc_we, pc_sel, instret, trap, trap_cause};

  // Expected control vector, fields in the same order as obs.
  function automatic logic [20:0] ctl(input logic [2:0] st, input logic req, input logic [1:0] imm,
                                      input logic sa, input logic sb, input logic [1:0] op,
                                      input logic re, input logic we, input logic rfw,
                                      input logic [1:0] wb, input logic pcw, input logic pcs,
                                      input logic ret, input logic tr, input logic [1:0] cause);
    return {st, req, imm, sa, sb, op, re, we, rfw, wb, pcw, pcs, ret, tr, cause};
  endfunction

  task automatic applyStimulus(input logic [31:0] rdata, input logic iready,
                               input logic dready, input logic brt);
    instr_rdata = rdata;
    imem_ready  = iready;
    dmem_ready  = dready;
    br_taken    = brt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Check the current cycle's outputs, then advance past the next rising edge.
  task automatic step(input string tag, input logic [20:0] expected);
    #1;
    checkOutput(tag, {11'b0, obs}, {11'b0, expected});
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_cycle(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_outs"}, {11'b0, obs}, 32'h0);
    checkOutput({tag, "_ir"}, ir_q, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [20:0] ZERO = 21'h0;

  initial begin
    rst_n = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outs", {11'b0, obs}, 32'h0);
    checkOutput("reset_ir", ir_q, 32'h0);
    rst_n = 1'b1;

    // addi x1,x0,5
    applyStimulus(I_ADDI, 1'b1, 1'b0, 1'b0);
    step("addi_idle",   ZERO);
    step("addi_fetch",  ctl(3'd1,1,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    checkOutput("addi_ir", ir_q, I_ADDI);
    applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
    step("addi_decode", ctl(3'd2,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("addi_exec",   ctl(3'd3,0,2'b00,0,1,2'b10,0,0,0,2'b00,0,0,0,0,2'b00));
    step("addi_wb",     ctl(3'd5,0,2'b00,0,0,2'b00,0,0,1,2'b00,1,0,1,0,2'b00));

    // lw x3,0(x2); dmem_ready on the 4th MEM cycle, which is also the watchdog limit
    applyStimulus(I_LW, 1'b1, 1'b0, 1'b0);
    step("lw_fetch",  ctl(3'd1,1,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
    step("lw_decode", ctl(3'd2,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("lw_exec",   ctl(3'd3,0,2'b00,0,1,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("lw_mem1",   ctl(3'd4,0,2'b00,0,1,2'b00,1,0,0,2'b00,0,0,0,0,2'b00));
    step("lw_mem2",   ctl(3'd4,0,2'b00,0,1,2'b00,1,0,0,2'b00,0,0,0,0,2'b00));
    step("lw_mem3",   ctl(3'd4,0,2'b00,0,1,2'b00,1,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_LW, 1'b0, 1'b1, 1'b0);
    step("lw_mem4",   ctl(3'd4,0,2'b00,0,1,2'b00,1,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_SW, 1'b0, 1'b0, 1'b0);
    step("lw_wb",     ctl(3'd5,0,2'b00,0,0,2'b00,0,0,1,2'b01,1,0,1,0,2'b00));

    // sw x1,4(x2); one MEM wait then ready
    applyStimulus(I_SW, 1'b1, 1'b0, 1'b0);
    step("sw_fetch",  ctl(3'd1,1,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_SW, 1'b0, 1'b0, 1'b0);
    step("sw_decode", ctl(3'd2,0,2'b01,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("sw_exec",   ctl(3'd3,0,2'b01,0,1,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("sw_mem1",   ctl(3'd4,0,2'b01,0,1,2'b00,0,1,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_SW, 1'b0, 1'b1, 1'b0);
    step("sw_mem2",   ctl(3'd4,0,2'b01,0,1,2'b00,0,1,0,2'b00,1,0,1,0,2'b00));

    // beq taken
    applyStimulus(I_BEQ, 1'b1, 1'b0, 1'b1);
    step("beq1_fetch",  ctl(3'd1,1,2'b01,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b1);
    step("beq1_decode", ctl(3'd2,0,2'b10,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("beq1_exec",   ctl(3'd3,0,2'b10,1,1,2'b11,0,0,0,2'b00,1,1,1,0,2'b00));

    // beq not taken
    applyStimulus(I_BEQ, 1'b1, 1'b0, 1'b0);
    step("beq0_fetch",  ctl(3'd1,1,2'b10,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_BEQ, 1'b0, 1'b0, 1'b0);
    step("beq0_decode", ctl(3'd2,0,2'b10,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("beq0_exec",   ctl(3'd3,0,2'b10,0,0,2'b11,0,0,0,2'b00,1,0,1,0,2'b00));

    // jal x1,16
    applyStimulus(I_JAL, 1'b1, 1'b0, 1'b0);
    step("jal_fetch",  ctl(3'd1,1,2'b10,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_JAL, 1'b0, 1'b0, 1'b0);
    step("jal_decode", ctl(3'd2,0,2'b11,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("jal_exec",   ctl(3'd3,0,2'b11,1,1,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("jal_wb",     ctl(3'd5,0,2'b11,1,1,2'b00,0,0,1,2'b10,1,1,1,0,2'b00));

    // lw whose data side never answers: 4 MEM cycles then data-side timeout
    applyStimulus(I_LW, 1'b1, 1'b0, 1'b0);
    step("dto_fetch",  ctl(3'd1,1,2'b11,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_LW, 1'b0, 1'b0, 1'b0);
    step("dto_decode", ctl(3'd2,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("dto_exec",   ctl(3'd3,0,2'b00,0,1,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    for (int i = 0; i < 4; i++)
      step("dto_mem",  ctl(3'd4,0,2'b00,0,1,2'b00,1,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_JAL, 1'b1, 1'b1, 1'b1);
    step("dto_trap1",  ctl(3'd6,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,1,2'b11));
    step("dto_trap2",  ctl(3'd6,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,1,2'b11));
    reset_mid_cycle("dto_rst");

    // illegal opcode
    applyStimulus(I_BAD, 1'b1, 1'b0, 1'b0);
    step("ill_idle",   ZERO);
    step("ill_fetch",  ctl(3'd1,1,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    applyStimulus(I_BAD, 1'b0, 1'b0, 1'b0);
    step("ill_decode", ctl(3'd2,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("ill_trap1",  ctl(3'd6,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,1,2'b01));
    step("ill_trap2",  ctl(3'd6,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,1,2'b01));
    reset_mid_cycle("ill_rst");

    // instruction side never answers: 4 FETCH cycles then timeout
    applyStimulus(I_ADDI, 1'b0, 1'b0, 1'b0);
    step("ito_idle", ZERO);
    for (int i = 0; i < 4; i++)
      step("ito_fetch", ctl(3'd1,1,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,0,2'b00));
    step("ito_trap1", ctl(3'd6,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,1,2'b10));
    applyStimulus(I_ADDI, 1'b1, 1'b1, 1'b0);
    step("ito_trap2", ctl(3'd6,0,2'b00,0,0,2'b00,0,0,0,2'b00,0,0,0,1,2'b10));
    reset_mid_cycle("ito_rst");
    step("ito_idle2", ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
